seq_input_checker: RTL and testbench

- Player-side counterpart of the sequence decoder: encodes one-hot button presses and checks them, step by step, against the one-hot colour the sequence decoder returns for each address.
- Drives the decoder's address and consumes its one-hot output, so one round of the memory game is verified in order from index 0 to the round limit.
- Sits between the synchronized/debounced button inputs and the game controller FSM.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/seq_input_checker_onehot_enc.sv | 27 ++
 rtl/seq_input_checker.sv | 186 ++++++++++++++++++
 tb/tb_seq_input_checker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the player-input sequence checker.
// Colour codes equal the bit position of that colour in the one-hot bus.
// Pure declarations: no latency, no flow control.
package seq_pkg;

  localparam int ADDR_W = 4;
  localparam int BTN_W  = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    CHECK        = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] GREEN  = 2'd0;
  localparam logic [1:0] RED    = 2'd1;
  localparam logic [1:0] BLUE   = 2'd2;
  localparam logic [1:0] YELLOW = 2'd3;

endpackage

// File: rtl/seq_input_checker_onehot_enc.sv
// One-hot to 2-bit colour code encoder with a "exactly one bit set" flag.
// Latency: purely combinational.
// Backpressure: none.
// Ports: in (W-bit one-hot candidate), code (colour code, 0 when invalid),
//        valid (1 only when exactly one bit of in is set).
module onehot_enc #(
  parameter int W = seq_pkg::BTN_W
) (
  input  logic [W-1:0] in,
  output logic [1:0]   code,
  output logic         valid
);
  import seq_pkg::*;

  always_comb begin
    code  = GREEN;
    valid = 1'b1;
    case (in)
      W'(1) << GREEN:  code = GREEN;
      W'(1) << RED:    code = RED;
      W'(1) << BLUE:   code = BLUE;
      W'(1) << YELLOW: code = YELLOW;
      default:         valid = 1'b0; // zero or several buttons
    endcase
  end

endmodule

// File: rtl/seq_input_checker.sv
// Checks one round of player presses against the sequence decoder, index 0..round.
// Latency: press edge at clock k -> press_valid in k+1 -> match_pulse/error in k+2.
// Backpressure: none; the player paces the check by pressing and releasing.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start, round    begin a round (ignored while busy), last index to check
//   buttons         debounced button levels, active high
//   seq_addr        address to the sequence decoder (= index)
//   seq_data        one-hot expected colour returned for seq_addr
//   busy            high from accepted start until round_ok/error
//   press_valid     one-cycle pulse per captured press; press_code is its colour code
//   match_pulse     one-cycle pulse when the captured press equals the expected colour
//   round_ok        one-cycle pulse when all indices 0..round matched
//   error           one-cycle pulse on wrong, multi-button or timed-out press
//   index           current index; holds the failing index until the next start
//
// Optional: define SEQ_INPUT_TIMEOUT_EN to fail a press that does not arrive
// within TIMEOUT_CYCLES cycles of entering WAIT_PRESS.
module seq_input_checker #(
  parameter int ADDR_W         = seq_pkg::ADDR_W,
  parameter int BTN_W          = seq_pkg::BTN_W,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] round,
  input  logic [BTN_W-1:0]  buttons,
  output logic [ADDR_W-1:0] seq_addr,
  input  logic [BTN_W-1:0]  seq_data,
  output logic              busy,
  output logic              press_valid,
  output logic [1:0]        press_code,
  output logic              match_pulse,
  output logic              round_ok,
  output logic              error,
  output logic [ADDR_W-1:0] index
);
  import seq_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] round_q, round_d;
  logic [BTN_W-1:0]  press_q, press_d;
  logic [BTN_W-1:0]  btn_prev;
  logic              busy_q, busy_d;
  logic              pv_q, pv_d;
  logic              match_q, match_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;

  logic              press_edge;
  logic [1:0]        enc_code;
  logic              enc_valid;
  logic              timeout_hit;

  // A press needs every button up on the previous cycle, so a button held
  // across start (or a second button added to a held one) never counts.
  assign press_edge = (btn_prev == '0) && (buttons != '0);

  // One encoder on the captured press serves both press_code and the
  // multi-button check performed in CHECK.
  onehot_enc #(.W(BTN_W)) u_enc (
    .in    (press_q),
    .code  (enc_code),
    .valid (enc_valid)
  );

`ifdef SEQ_INPUT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Held at zero outside WAIT_PRESS, so every entry starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     to_cnt <= '0;
    else if (state_q != WAIT_PRESS) to_cnt <= '0;
    else if (!timeout_hit)         to_cnt <= to_cnt + TO_W'(1);
  end

  assign timeout_hit = (state_q == WAIT_PRESS) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      index_q  <= '0;
      round_q  <= '0;
      press_q  <= '0;
      btn_prev <= '0;
      busy_q   <= 1'b0;
      pv_q     <= 1'b0;
      match_q  <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      round_q  <= round_d;
      press_q  <= press_d;
      btn_prev <= buttons;
      busy_q   <= busy_d;
      pv_q     <= pv_d;
      match_q  <= match_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    round_d = round_q;
    press_d = press_q;
    busy_d  = busy_q;
    pv_d    = 1'b0;
    match_d = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          round_d = round;
          index_d = '0;
          busy_d  = 1'b1;
          state_d = WAIT_PRESS;
        end
      end

      WAIT_PRESS: begin
        // A press on the expiring cycle takes priority over the timeout.
        if (press_edge) begin
          press_d = buttons;
          pv_d    = 1'b1;
          state_d = CHECK;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      CHECK: begin
        if (!enc_valid || (press_q != seq_data)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          match_d = 1'b1;
          state_d = WAIT_RELEASE;
        end
      end

      WAIT_RELEASE: begin
        if (buttons == '0) begin
          if (index_q == round_q) begin
            ok_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // index < round here, so the increment cannot wrap.
            index_d = index_q + ADDR_W'(1);
            state_d = WAIT_PRESS;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign seq_addr    = index_q;
  assign index       = index_q;
  assign busy        = busy_q;
  assign press_valid = pv_q;
  assign press_code  = enc_code;
  assign match_pulse = match_q;
  assign round_ok    = ok_q;
  assign error       = err_q;

endmodule

// File: tb/tb_seq_input_checker.sv
// Bench for seq_input_checker: behavioural sequence decoder plus a scoreboard
// of expected pulses (press/match/round_ok/error) compared as the DUT emits them.
// Build with or without SEQ_INPUT_TIMEOUT_EN; TIMEOUT_CYCLES is set to 16.
module tb_seq_input_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] round;
  logic [3:0] buttons;
  logic [3:0] seq_addr;
  logic [3:0] seq_data;
  logic       busy;
  logic       press_valid;
  logic [1:0] press_code;
  logic       match_pulse;
  logic       round_ok;
  logic       error;
  logic [3:0] index;

  logic [3:0] dec_tab [16];

  typedef struct {
    int kind;   // 0 press code, 1 match, 2 round_ok, 3 error
    int val;    // code or index; negative = don't care
  } ev_t;
  ev_t sbq[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Sequence decoder model: combinational lookup on the address.
  assign seq_data = dec_tab[seq_addr];

  seq_input_checker #(
    .ADDR_W         (4),
    .BTN_W          (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .round       (round),
    .buttons     (buttons),
    .seq_addr    (seq_addr),
    .seq_data    (seq_data),
    .busy        (busy),
    .press_valid (press_valid),
    .press_code  (press_code),
    .match_pulse (match_pulse),
    .round_ok    (round_ok),
    .error       (error),
    .index       (index)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int exp_code(input logic [3:0] b);
    if ($countones(b) != 1) return -1;
    for (int i = 0; i < 4; i++)
      if (b[i]) return i;
    return -1;
  endfunction

  task automatic sb_push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input int val);
    ev_t e;
    if (sbq.size() == 0) begin
      chk("sb_unexpected_pulse_kind", kind, -1);
    end else begin
      e = sbq.pop_front();
      chk("sb_pulse_kind", kind, e.kind);
      if (e.val >= 0) begin
        case (kind)
          0:       chk("sb_press_code", val, e.val);
          1:       chk("sb_match_index", val, e.val);
          2:       chk("sb_round_ok_index", val, e.val);
          default: chk("sb_error_index", val, e.val);
        endcase
      end
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (press_valid) sb_pop(0, int'(press_code));
      if (match_pulse) sb_pop(1, int'(index));
      if (round_ok)    sb_pop(2, int'(index));
      if (error)       sb_pop(3, int'(index));
    end
  end

  task automatic do_start(input logic [3:0] r);
    start = 1'b1;
    round = r;
    cyc(1);
    start = 1'b0;
  endtask

  // Press b at index idx of a round ending at rnd, hold, release, settle.
  task automatic press_step(input logic [3:0] b, input int idx, input int rnd);
    logic [3:0] e;
    e = dec_tab[idx];
    sb_push(0, exp_code(b));
    if ($countones(b) == 1 && b == e) begin
      sb_push(1, idx);
      if (idx == rnd) sb_push(2, idx);
    end else begin
      sb_push(3, idx);
    end
    buttons = b;
    cyc(3);
    buttons = 4'b0000;
    cyc(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat [8];
    pat[0] = 4'b0001; pat[1] = 4'b0100; pat[2] = 4'b0010; pat[3] = 4'b1000;
    pat[4] = 4'b0001; pat[5] = 4'b0010; pat[6] = 4'b0100; pat[7] = 4'b1000;
    for (int i = 0; i < 16; i++) dec_tab[i] = pat[i % 8];

    reset   = 1'b1;
    start   = 1'b0;
    round   = 4'd0;
    buttons = 4'b0000;
    cyc(3);
    chk("reset_pulses", int'({busy, press_valid, match_pulse, round_ok, error}), 0);
    chk("reset_index", int'(index), 0);
    chk("reset_code", int'(press_code), 0);
    reset = 1'b0;
    cyc(2);
    chk("idle_busy", int'(busy), 0);

    // Full round 0..2: presses 0001, 0100, 0010; exact latency on the first.
    do_start(4'd2);
    chk("start_busy", int'(busy), 1);
    chk("start_index", int'(index), 0);
    sb_push(0, 0);
    sb_push(1, 0);
    buttons = 4'b0001;
    cyc(1);
    chk("lat_press_valid", int'(press_valid), 1);
    chk("lat_match_early", int'(match_pulse), 0);
    cyc(1);
    chk("lat_match", int'(match_pulse), 1);
    chk("lat_press_valid_pulse", int'(press_valid), 0);
    cyc(1);
    buttons = 4'b0000;
    cyc(2);
    chk("idx_after_release", int'(index), 1);
    press_step(4'b0100, 1, 2);
    press_step(4'b0010, 2, 2);
    chk("round_busy_low", int'(busy), 0);
    chk("round_index_hold", int'(index), 2);
    chk("sb_empty_round", sbq.size(), 0);

    // Wrong colour at index 1.
    do_start(4'd1);
    press_step(4'b0001, 0, 1);
    press_step(4'b1000, 1, 1);
    chk("wrong_index_hold", int'(index), 1);
    chk("wrong_busy_low", int'(busy), 0);
    chk("sb_empty_wrong", sbq.size(), 0);

    // Two buttons together on the first press.
    do_start(4'd0);
    press_step(4'b0011, 0, 0);
    chk("multi_index", int'(index), 0);
    chk("multi_busy_low", int'(busy), 0);
    chk("sb_empty_multi", sbq.size(), 0);

    // Button held across start, then released and pressed again; start while busy.
    buttons = 4'b0001;
    cyc(2);
    do_start(4'd0);
    cyc(2);
    chk("held_busy", int'(busy), 1);
    chk("held_no_press", int'(press_valid), 0);
    buttons = 4'b0000;
    cyc(1);
    do_start(4'd5);
    chk("restart_ignored_busy", int'(busy), 1);
    chk("restart_ignored_index", int'(index), 0);
    press_step(4'b0001, 0, 0);
    chk("held_busy_low", int'(busy), 0);
    chk("sb_empty_held", sbq.size(), 0);

    // Asynchronous reset mid-round at index 2.
    do_start(4'd3);
    press_step(4'b0001, 0, 3);
    press_step(4'b0100, 1, 3);
    chk("mid_index", int'(index), 2);
    chk("mid_code", int'(press_code), 2);
    reset = 1'b1;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_index", int'(index), 0);
    chk("async_code", int'(press_code), 0);
    chk("async_addr", int'(seq_addr), 0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("sb_empty_reset", sbq.size(), 0);
    do_start(4'd0);
    chk("post_reset_index", int'(index), 0);
    press_step(4'b0001, 0, 0);
    chk("sb_empty_post_reset", sbq.size(), 0);

    // No press at all.
    do_start(4'd0);
`ifdef SEQ_INPUT_TIMEOUT_EN
    sb_push(3, 0);
    cyc(15);
    chk("timeout_not_early", int'(busy), 1);
    cyc(1);
    chk("timeout_error", int'(error), 1);
    chk("timeout_busy_low", int'(busy), 0);
    chk("timeout_index", int'(index), 0);
    cyc(2);
`else
    cyc(20);
    chk("no_timeout_busy", int'(busy), 1);
    chk("no_timeout_index", int'(index), 0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
`endif
    chk("sb_empty_final", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
